fetch_queue: RTL
================

# fetch_queue

Instruction fetch stage directly downstream of the PC register. It takes the current word-indexed PC and issues in-order requests to instruction memory. Returned instructions are buffered with their PCs in a DEPTH-entry in-order queue and presented to decode over a valid/ready handshake. On a control-flow redirect it drops all queued and in-flight fetches, and it tells the PC stage when to advance.

## Interface
- DEPTH, 4, queue entries and maximum outstanding memory requests; power of 2, ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, active-low, asynchronous assert; deassertion is synchronized outside this block
- pc_in  in  32  current PC (word index) from the PC register
- pc_advance  out  1  PC stage steps to its next value this cycle
- flush  in  1  redirect: the branch/jump took, so discard everything
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch word address, equal to pc_in
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  instruction word returned; responses arrive in request order
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  decode-facing instruction valid
- instr_data  out  32  instruction
- instr_pc  out  32  PC of instr_data
- instr_ready  in  1  decode consumes

## Operation
- Queue entry fields: pc[31:0], instr[31:0], filled.
- Three pointers: alloc (written at request), fill (written at response), head (read at pop). Each is $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
- used = alloc − head. drop_cnt counts responses still owed to flushed requests and is $clog2(DEPTH)+1 bits.
- imem_req_valid = !flush && (used + drop_cnt < DEPTH).
- imem_req_addr = pc_in.
- Request fire (req_valid && req_ready): allocate entry at alloc with pc = pc_in and filled = 0, then alloc++.
- pc_advance = request fire. The PC holds whenever no request fires.
- Response with drop_cnt > 0: discard the data and decrement drop_cnt. Otherwise write instr into the entry at fill, set filled = 1, then fill++.
- instr_valid = entry[head].filled && !flush. instr_data and instr_pc come from entry[head].
- Pop (instr_valid && instr_ready): clear filled, then head++.
- Flush:
  - alloc, fill and head all reset to 0, and all filled bits clear.
  - drop_cnt ← drop_cnt + (alloc − fill) − (1 if a response arrives this cycle).
  - No request issues, and no pop occurs (instr_valid is forced 0).
- Simultaneous response + pop on the same entry is impossible: an entry becomes poppable only the cycle after it is filled.
- Simultaneous request + pop + response in one cycle is all legal and handled independently.
- Queue full (used = DEPTH): no request issues; the in-flight entries drain normally.
- Empty: instr_valid = 0.
- Pointer wrap: modulo 2·DEPTH, and the index is the low bits.

## Timing
- Reset (rst = 0, async): pointers 0, drop_cnt 0, filled bits 0. Outputs: instr_valid 0, pc_advance 0, imem_req_valid 0, instr_data 0, instr_pc 0.
- imem_req_addr follows pc_in at all times.
- First cycle after reset release: imem_req_valid = 1 with addr = pc_in.
- Memory latency ≥1 cycle after request accept, with no upper bound.
- Response in cycle N: instr_valid = 1 in cycle N+1.
- With a 1-cycle memory and instr_ready held at 1, throughput is one instruction per cycle with no bubbles. The first instruction appears 2 cycles after reset release.
- Flush in cycle N:
  - Cycle N: no request, no pop.
  - Cycle N+1: request for the new pc_in. The PC stage has already loaded the target, because sel_next_pc_alu_out coincides with flush.
- Reset mid-operation: every in-flight response is lost. The memory is reset by the same rst.

## Structure
- fetch_pkg holds:
  - typedef fq_entry_t {pc, instr, filled}
  - localparam INSTR_W = 32
- Sub-module fq_ptr: wrap-bit pointer register with increment and synchronous clear, instantiated three times (alloc, fill, head).

## Test plan
- 1-cycle memory returning pc+0x100, instr_ready = 1, after reset with PC starting at 0 → instr_pc 0,1,2,3… each cycle from cycle 2; instr_data 0x100,0x101,…; pc_advance held at 1.
- instr_ready = 0 with 1-cycle memory → exactly 4 requests fire, then imem_req_valid = 0 and pc_advance = 0. Raise ready → instructions 0–3 pop in order and fetch resumes at pc 4 with no loss or duplicate.
- imem_req_ready = 0 for 3 cycles at pc 5 → imem_req_addr stays 5, pc_advance stays 0, no entry is allocated.
- 3-cycle memory; requests for pcs 8 and 9 outstanding; flush with pc_in = 0x40 → the next 2 responses are discarded, and the first instr_valid shows instr_pc = 0x40.
- Flush coincident with a response, an instr_valid/instr_ready handshake, and 2 outstanding requests → no pop counted, drop_cnt = 1, and the single following response is discarded.
- rst pulled low asynchronously mid-stream with a full queue → instr_valid, imem_req_valid and pc_advance drop to 0 immediately. After release, fetch restarts at the current pc_in.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the instruction fetch queue
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// rtl/fq_ptr.sv - wrap-bit queue pointer with increment and synchronous clear
module fq_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Clear wins over increment so a redirect always restarts at index 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + PTR_W'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue between PC register and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [PC_W-1:0]    i_pc_in,
  output logic               o_pc_advance,
  input  logic               i_flush,
  output logic               o_imem_req_valid,
  output logic [PC_W-1:0]    o_imem_req_addr,
  input  logic               i_imem_req_ready,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr_data,
  output logic [PC_W-1:0]    o_instr_pc,
  input  logic               i_instr_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  fq_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_drop_cnt;

  logic [PTR_W-1:0] w_alloc_ptr;
  logic [PTR_W-1:0] w_fill_ptr;
  logic [PTR_W-1:0] w_head_ptr;
  logic [IDX_W-1:0] w_alloc_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_used;
  logic [PTR_W-1:0] w_in_flight;
  logic [PTR_W:0]   w_occupancy;
  logic             w_req_fire;
  logic             w_rsp_keep;
  logic             w_rsp_drop;
  logic             w_pop;

  assign w_alloc_idx = w_alloc_ptr[IDX_W-1:0];
  assign w_fill_idx  = w_fill_ptr[IDX_W-1:0];
  assign w_head_idx  = w_head_ptr[IDX_W-1:0];

  assign w_used      = w_alloc_ptr - w_head_ptr;
  assign w_in_flight = w_alloc_ptr - w_fill_ptr;
  // Responses still owed to flushed requests occupy memory slots too.
  assign w_occupancy = {1'b0, w_used} + {1'b0, r_drop_cnt};

  assign o_imem_req_valid = i_rst_n && !i_flush && (w_occupancy < (PTR_W+1)'(DEPTH));
  assign o_imem_req_addr  = i_pc_in;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;
  assign o_pc_advance     = w_req_fire;

  assign w_rsp_drop = i_imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_keep = i_imem_rsp_valid && (r_drop_cnt == '0) && !i_flush;

  assign o_instr_valid = r_entries[w_head_idx].filled && !i_flush;
  assign o_instr_data  = r_entries[w_head_idx].instr;
  assign o_instr_pc    = r_entries[w_head_idx].pc;
  assign w_pop         = o_instr_valid && i_instr_ready;

  fq_ptr #(.PTR_W(PTR_W)) u_alloc_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (w_req_fire),
    .o_ptr   (w_alloc_ptr)
  );

  fq_ptr #(.PTR_W(PTR_W)) u_fill_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (w_rsp_keep),
    .o_ptr   (w_fill_ptr)
  );

  fq_ptr #(.PTR_W(PTR_W)) u_head_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (w_pop),
    .o_ptr   (w_head_ptr)
  );

  // A response arriving during the flush cycle is already counted in the in-flight span.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (i_flush) begin
      r_drop_cnt <= r_drop_cnt + w_in_flight - PTR_W'(i_imem_rsp_valid);
    end else if (w_rsp_drop) begin
      r_drop_cnt <= r_drop_cnt - PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i].filled <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_entries[w_alloc_idx].pc     <= i_pc_in;
        r_entries[w_alloc_idx].filled <= 1'b0;
      end
      if (w_rsp_keep) begin
        r_entries[w_fill_idx].instr  <= i_imem_rsp_data;
        r_entries[w_fill_idx].filled <= 1'b1;
      end
      if (w_pop) r_entries[w_head_idx].filled <= 1'b0;
    end
  end

endmodule
